pipeline_stall_ctrl: RTL and testbench
======================================

// Module: pipeline_stall_ctrl
// PURPOSE
//  Sequencing controller for the 5-stage LC-3b pipeline register set (pc, if_id, id_ex, ex_mem, mem_wb).
//  Issues I/D memory requests, holds every stage until all outstanding memory responses are in,
//  then advances the pipe in one cycle. Applies load-use bubbles and branch flushes.
//  Keeps stall statistics and a memory-timeout watchdog.
// PARAMETERS
//  CNT_WIDTH   16    width of stall_count (saturating)
//  WAIT_LIMIT  1023  consecutive stalled cycles before mem_timeout sets (range 1..2^CNT_WIDTH-1)
// PORTS
//  clk            in   1  rising-edge clock
//  reset_n        in   1  asynchronous, active-low reset
//  i_resp         in   1  instruction memory response, 1-cycle pulse
//  d_req_read     in   1  EX/MEM control word requests a data read
//  d_req_write    in   1  EX/MEM control word requests a data write
//  d_resp         in   1  data memory response, 1-cycle pulse
//  load_use       in   1  hazard unit: ID instruction needs the load now in EX
//  branch_taken   in   1  MEM-stage branch/jump resolved taken
//  i_read         out  1  instruction memory read strobe
//  d_read         out  1  data memory read strobe
//  d_write        out  1  data memory write strobe
//  load_pc        out  1  PC register load
//  load_if_id     out  1  IF/ID load
//  load_id_ex     out  1  ID/EX load
//  load_ex_mem    out  1  EX/MEM load
//  load_mem_wb    out  1  MEM/WB load
//  flush_if_id    out  1  IF/ID loads NOP control word (valid with load_if_id)
//  flush_id_ex    out  1  ID/EX loads NOP control word (valid with load_id_ex)
//  stalled        out  1  state == STALL
//  stall_count    out  CNT_WIDTH  total stalled cycles since reset, saturates at all-ones
//  mem_timeout    out  1  sticky; set when a stall run reaches WAIT_LIMIT cycles
// BEHAVIOUR
//  Reset (reset_n=0, async): i_done, d_done, state=RUN, stall_count=0, run_len=0, mem_timeout=0.
//   While reset_n=0, every output is forced to 0.
//  d_req   = d_req_read | d_req_write.
//  i_ok    = i_resp | i_done.   d_ok = ~d_req | d_resp | d_done.   advance = i_ok & d_ok.
//  Strobes: i_read = ~i_done.   d_read = d_req_read & ~d_done.   d_write = d_req_write & ~d_done.
//   Each strobe is held high until its response arrives.
//   d_req_read and d_req_write high together is illegal and unchecked.
//  Sticky flags:
//   - i_resp & ~advance sets i_done; d_resp & ~advance sets d_done. The early response is not re-requested.
//   - advance clears both flags. Both are cleared on the clock edge where advance is seen.
//  Advance is combinational and same-cycle; zero added latency when both responses land together.
//  When advance=1:
//   - branch_taken (highest priority): all loads=1; flush_if_id=1, flush_id_ex=1; load_use ignored.
//   - else load_use: load_pc=0, load_if_id=0; load_id_ex=1 with flush_id_ex=1;
//     load_ex_mem=1, load_mem_wb=1. The fetched instruction is discarded and refetched next cycle.
//   - else all loads=1, no flush.
//  When advance=0: all load_* and flush_* outputs are 0.
//  FSM:
//   - RUN -> STALL when advance=0. STALL -> RUN when advance=1. Otherwise hold.
//  Counters:
//   - stall_count += 1 on each cycle with advance=0; holds at 2^CNT_WIDTH-1.
//   - run_len counts consecutive advance=0 cycles and is cleared when advance=1.
//   - mem_timeout is set when run_len == WAIT_LIMIT-1 and advance=0. It stays set until reset.
//   - The pipe keeps waiting after a timeout; it does not abort.
//  A response with no strobe outstanding (e.g. second i_resp while i_done=1) is ignored.
//  Reset mid-stall: strobes drop immediately (async). The first cycle after reset re-requests the fetch.
// TESTING
//  1 Reset, then i_resp every cycle, d_req=0 -> all loads=1 each cycle, stalled=0, stall_count=0.
//  2 d_req_read=1; i_resp at cycle 2, d_resp at cycle 5 ->
//    i_read drops after cycle 2, d_read high cycles 0-5, advance at 5, stall_count=5.
//  3 load_use=1 with i_resp -> load_pc=0, load_if_id=0, load_id_ex=1, flush_id_ex=1;
//    next cycle i_read=1.
//  4 branch_taken=1 with load_use=1 and advance -> load_pc=1, flush_if_id=1, flush_id_ex=1.
//  5 WAIT_LIMIT=4, no i_resp for 6 cycles -> mem_timeout=1 after the 4th stalled cycle;
//    stays 1 after a later i_resp.
//  6 Assert reset_n=0 mid-stall with d_done=1 -> outputs 0 immediately;
//    after release stall_count=0 and the data request is reissued.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline sequencing controller for the five LC-3b pipeline register sets.
// It issues I/D memory strobes and holds all stages until the outstanding
// responses are in. It then advances the pipe in the same cycle, applying
// load-use bubbles and branch flushes. It also keeps a saturating stall
// counter and a sticky memory-timeout watchdog.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_RUN   | previous cycle advanced the pipe
// ST_STALL | previous cycle was held waiting on a memory response
module pipeline_stall_ctrl #(
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned WAIT_LIMIT = 1023
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_resp,
    input  logic                 d_req_read,
    input  logic                 d_req_write,
    input  logic                 d_resp,
    input  logic                 load_use,
    input  logic                 branch_taken,
    output logic                 i_read,
    output logic                 d_read,
    output logic                 d_write,
    output logic                 load_pc,
    output logic                 load_if_id,
    output logic                 load_id_ex,
    output logic                 load_ex_mem,
    output logic                 load_mem_wb,
    output logic                 flush_if_id,
    output logic                 flush_id_ex,
    output logic                 stalled,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic                 mem_timeout
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    // The watchdog is a down-counter. Terminal count 0 means WAIT_LIMIT-1
    // consecutive stalled cycles have already elapsed.
    localparam logic [CNT_WIDTH-1:0] TMR_INIT = CNT_WIDTH'(WAIT_LIMIT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    state_t               state_q, state_d;
    logic                 i_done_q, i_done_d;
    logic                 d_done_q, d_done_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] wait_tmr_q, wait_tmr_d;
    logic                 timeout_q, timeout_d;

    logic d_req;
    logic i_ok;
    logic d_ok;
    logic advance;

    assign d_req   = d_req_read | d_req_write;
    assign i_ok    = i_resp | i_done_q;
    assign d_ok    = ~d_req | d_resp | d_done_q;
    assign advance = i_ok & d_ok;

    // Next-state: sticky response flags, stall FSM, counters and watchdog
    always_comb begin
        i_done_d    = i_done_q;
        d_done_d    = d_done_q;
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        wait_tmr_d  = wait_tmr_q;
        timeout_d   = timeout_q;

        if (advance) begin
            // Both flags drop on the edge that consumes them.
            i_done_d   = 1'b0;
            d_done_d   = 1'b0;
            state_d    = ST_RUN;
            wait_tmr_d = TMR_INIT;
        end else begin
            // An early response is remembered so it is not re-requested.
            // A data response with no data request outstanding is dropped.
            if (i_resp) begin
                i_done_d = 1'b1;
            end
            if (d_req && d_resp) begin
                d_done_d = 1'b1;
            end
            state_d = ST_STALL;
            if (stall_cnt_q != CNT_MAX) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (wait_tmr_q == '0) begin
                timeout_d = 1'b1;
            end else begin
                wait_tmr_d = wait_tmr_q - 1'b1;
            end
        end
    end

    // State, flags and statistics registers; async active-low clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_RUN;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            stall_cnt_q <= '0;
            wait_tmr_q  <= TMR_INIT;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_done_q    <= i_done_d;
            d_done_q    <= d_done_d;
            stall_cnt_q <= stall_cnt_d;
            wait_tmr_q  <= wait_tmr_d;
            timeout_q   <= timeout_d;
        end
    end

    // Same-cycle strobes and pipeline load/flush controls. These are gated
    // by reset_n so that everything reads 0 while reset is held.
    always_comb begin
        i_read      = 1'b0;
        d_read      = 1'b0;
        d_write     = 1'b0;
        load_pc     = 1'b0;
        load_if_id  = 1'b0;
        load_id_ex  = 1'b0;
        load_ex_mem = 1'b0;
        load_mem_wb = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;

        if (reset_n) begin
            i_read  = ~i_done_q;
            d_read  = d_req_read & ~d_done_q;
            d_write = d_req_write & ~d_done_q;

            if (advance) begin
                load_id_ex  = 1'b1;
                load_ex_mem = 1'b1;
                load_mem_wb = 1'b1;
                if (branch_taken) begin
                    load_pc     = 1'b1;
                    load_if_id  = 1'b1;
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                end else if (load_use) begin
                    // Hold PC and IF/ID and bubble ID/EX. The fetched
                    // instruction is thrown away and fetched again.
                    flush_id_ex = 1'b1;
                end else begin
                    load_pc    = 1'b1;
                    load_if_id = 1'b1;
                end
            end
        end
    end

    assign stalled     = (state_q == ST_STALL);
    assign stall_count = stall_cnt_q;
    assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
module tb_pipeline_stall_ctrl;

    localparam int CW  = 6;
    localparam int WL  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          i_resp, d_req_read, d_req_write, d_resp, load_use, branch_taken;
    logic          i_read, d_read, d_write;
    logic          load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic          flush_if_id, flush_id_ex, stalled, mem_timeout;
    logic [CW-1:0] stall_count;

    int checks = 0;
    int errors = 0;

    // Reference model: "have we already received this response since the
    // last advance", plus plain integer statistics.
    bit m_got_i, m_got_d, m_stalled, m_tmo;
    int m_total, m_run;

    pipeline_stall_ctrl #(.CNT_WIDTH(CW), .WAIT_LIMIT(WL)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_resp(i_resp), .d_req_read(d_req_read), .d_req_write(d_req_write),
        .d_resp(d_resp), .load_use(load_use), .branch_taken(branch_taken),
        .i_read(i_read), .d_read(d_read), .d_write(d_write),
        .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
        .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .stalled(stalled), .stall_count(stall_count), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_got_i = 0; m_got_d = 0; m_stalled = 0; m_tmo = 0;
        m_total = 0; m_run = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_strobes"}, {29'd0, i_read, d_read, d_write}, 32'd0);
        chk({tag, "_loads"}, {27'd0, load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb}, 32'd0);
        chk({tag, "_flush"}, {30'd0, flush_if_id, flush_id_ex}, 32'd0);
        chk({tag, "_stat"}, {30'd0, stalled, mem_timeout}, 32'd0);
        chk({tag, "_count"}, 32'(stall_count), 32'd0);
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic cycle(input string tag, input bit ir, input bit dr, input bit dw,
                         input bit dresp, input bit lu, input bit bt);
        bit adv, dq;
        logic [4:0] e_ld;
        logic [1:0] e_fl;
        i_resp = ir; d_req_read = dr; d_req_write = dw;
        d_resp = dresp; load_use = lu; branch_taken = bt;
        #1;
        dq  = dr | dw;
        adv = (ir || m_got_i) && (!dq || dresp || m_got_d);
        if (!adv)     begin e_ld = 5'b00000; e_fl = 2'b00; end
        else if (bt)  begin e_ld = 5'b11111; e_fl = 2'b11; end
        else if (lu)  begin e_ld = 5'b00111; e_fl = 2'b01; end
        else          begin e_ld = 5'b11111; e_fl = 2'b00; end
        chk({tag, "_strobes"}, {29'd0, i_read, d_read, d_write},
            {29'd0, !m_got_i, dr && !m_got_d, dw && !m_got_d});
        chk({tag, "_loads"}, {27'd0, load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb},
            {27'd0, e_ld});
        chk({tag, "_flush"}, {30'd0, flush_if_id, flush_id_ex}, {30'd0, e_fl});
        chk({tag, "_stalled"}, {31'd0, stalled}, {31'd0, m_stalled});
        chk({tag, "_count"}, 32'(stall_count), 32'(m_total));
        chk({tag, "_timeout"}, {31'd0, mem_timeout}, {31'd0, m_tmo});
        @(posedge clk);
        if (adv) begin
            m_got_i = 0; m_got_d = 0; m_stalled = 0; m_run = 0;
        end else begin
            if (ir) m_got_i = 1;
            if (dq && dresp) m_got_d = 1;
            m_stalled = 1;
            if (m_total < SAT) m_total++;
            m_run++;
            if (m_run >= WL) m_tmo = 1;
        end
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        i_resp = 0; d_req_read = 0; d_req_write = 0; d_resp = 0; load_use = 0; branch_taken = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;

        // 1: fetch responds every cycle, no data access
        for (int i = 0; i < 4; i++) cycle("t1_flow", 1, 0, 0, 0, 0, 0);

        // 2: data read; i_resp at cycle 2, d_resp at cycle 5
        for (int c = 0; c <= 5; c++) cycle("t2_dread", c == 2, 1, 0, c == 5, 0, 0);
        chk("t2_count5", 32'(stall_count), 32'd5);

        // 3: load-use bubble, then refetch
        cycle("t3_loaduse", 1, 0, 0, 0, 1, 0);
        cycle("t3_refetch", 1, 0, 0, 0, 0, 0);

        // 4: branch beats load-use
        cycle("t4_branch", 1, 0, 0, 0, 1, 1);

        // Data write with responses in the opposite order
        cycle("wr_a", 0, 0, 1, 1, 0, 0);
        cycle("wr_b", 1, 0, 1, 0, 0, 0);

        // 5: six cycles without a fetch response triggers the watchdog
        for (int c = 0; c < 6; c++) cycle("t5_wait", 0, 0, 0, 0, 0, 0);
        chk("t5_timeout_set", {31'd0, mem_timeout}, 32'd1);
        cycle("t5_resume", 1, 0, 0, 0, 0, 0);
        cycle("t5_after", 1, 0, 0, 0, 0, 0);
        chk("t5_timeout_sticky", {31'd0, mem_timeout}, 32'd1);

        // 6: reset mid-stall with the data response already captured
        cycle("t6_dearly", 0, 1, 0, 1, 0, 0);
        cycle("t6_hold", 0, 1, 0, 0, 0, 0);
        d_req_read = 1; i_resp = 0; d_resp = 0;
        #3 reset_n = 1'b0;
        #1 check_all_zero("t6_async");
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        cycle("t6_reissue", 0, 1, 0, 0, 0, 0);
        chk("t6_dread_again", {31'd0, d_read}, 32'd1);

        // Random traffic against the model
        for (int n = 0; n < 500; n++) begin
            int kind;
            kind = $urandom_range(0, 2);
            cycle("rnd", $urandom_range(0, 2) == 0, kind == 1, kind == 2,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 4) == 0);
        end
        chk("rnd_saturated", 32'(stall_count), 32'(SAT));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
